// File: rtl/conv_result_writer.sv
// conv_result_writer: write-back mover for the convolution GEMM path.
// Takes rows of signed accumulator lanes, applies optional ReLU, an arithmetic
// right shift and saturation to OUT_WIDTH, packs the lanes into one word and
// writes the tile sequentially into the output BRAM through one write port.
module conv_result_writer #(
    parameter int MEM_DEPTH      = 896,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int PE_SIZE        = 16,
    parameter int ACC_WIDTH      = 32,
    parameter int OUT_WIDTH      = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic [4:0]                     shift_i,
    input  logic                           relu_en_i,
    input  logic                           acc_valid_i,
    input  logic [PE_SIZE*ACC_WIDTH-1:0]   acc_data_i,
    output logic [MEM_ADDR_WIDTH-1:0]      mem_addr0,
    output logic                           mem_ce0,
    output logic                           mem_we0,
    output logic [PE_SIZE*OUT_WIDTH-1:0]   mem_d0,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           overflow_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    // Address of the final word of a tile; accepting it ends the RUN phase.
    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);

    // Saturation bounds expressed at full accumulator width so the comparison
    // happens on the shifted value before any narrowing.
    localparam int SAT_MAX_INT = (2 ** (OUT_WIDTH - 1)) - 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(SAT_MAX_INT);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-SAT_MAX_INT - 1);

    state_t                      state;
    logic [MEM_ADDR_WIDTH-1:0]   counter;
    logic [4:0]                  shift_q;
    logic                        relu_q;
    logic [PE_SIZE*OUT_WIDTH-1:0] quant_word;

    // One lane: ReLU clamp, arithmetic shift (rounds toward -inf), saturate.
    function automatic logic [OUT_WIDTH-1:0] quantize(
        input logic signed [ACC_WIDTH-1:0] value,
        input logic [4:0]                  shift,
        input logic                        relu
    );
        logic signed [ACC_WIDTH-1:0] shifted;
        if (relu && value[ACC_WIDTH-1]) begin
            return '0;
        end
        shifted = value >>> shift;
        if (shifted > SAT_MAX) begin
            return SAT_MAX[OUT_WIDTH-1:0];
        end
        if (shifted < SAT_MIN) begin
            return SAT_MIN[OUT_WIDTH-1:0];
        end
        return shifted[OUT_WIDTH-1:0];
    endfunction

    // Quantize every lane of the incoming row with the settings latched at start.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        quant_word = '0;
        for (int i = 0; i < PE_SIZE; i++) begin
            quant_word[i*OUT_WIDTH +: OUT_WIDTH] =
                quantize(acc_data_i[i*ACC_WIDTH +: ACC_WIDTH], shift_q, relu_q);
        end
    end

    // Tile sequencing FSM with registered BRAM port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the write-data register is a plain pipeline flop, not a memory, so it is reset like any other output.
            state      <= IDLE;
            counter    <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            mem_addr0  <= '0;
            mem_ce0    <= 1'b0;
            mem_we0    <= 1'b0;
            mem_d0     <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            mem_ce0 <= 1'b0;
            mem_we0 <= 1'b0;
            done_o  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= RUN;
                        counter    <= '0;
                        shift_q    <= shift_i;
                        relu_q     <= relu_en_i;
                        overflow_o <= 1'b0;
                        busy_o     <= 1'b1;
                    end else if (acc_valid_i) begin
                        overflow_o <= 1'b1;
                    end
                end

                RUN: begin
                    if (acc_valid_i) begin
                        mem_d0    <= quant_word;
                        mem_addr0 <= counter;
                        mem_ce0   <= 1'b1;
                        mem_we0   <= 1'b1;
                        counter   <= counter + MEM_ADDR_WIDTH'(1);
                        if (counter == LAST_ADDR) begin
                            state <= FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    if (acc_valid_i) begin
                        overflow_o <= 1'b1;
                    end
                    state  <= DONE;
                    done_o <= 1'b1;
                end

                DONE: begin
                    if (acc_valid_i) begin
                        overflow_o <= 1'b1;
                    end
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed testbench for conv_result_writer: reset/idle, full tiles,
// quantization corner values, gapped input, overflow flag and mid-tile reset.
module tb_conv_result_writer;

    localparam int MEM_DEPTH = 896;
    localparam int AW        = 10;
    localparam int PE        = 16;
    localparam int AC        = 32;
    localparam int OW        = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [4:0]        shift_i;
    logic              relu_en_i;
    logic              acc_valid_i;
    logic [PE*AC-1:0]  acc_data_i;
    logic [AW-1:0]     mem_addr0;
    logic              mem_ce0;
    logic              mem_we0;
    logic [PE*OW-1:0]  mem_d0;
    logic              busy_o;
    logic              done_o;
    logic              overflow_o;

    int n_checks = 0;
    int n_fails  = 0;

    // Quantization corner values, placed on lanes in rotation.
    logic signed [31:0] qvals [8] = '{32'sh7FFFFFFF, -32'sd1000, 32'sd2047, -32'sd17,
                                      32'sd40, 32'sh80000000, 32'sd3000, -32'sd2000};
    // Hand-computed results for lanes 0..7 of row 0 at shift=4.
    logic signed [7:0] hand_relu0 [8] = '{8'sd127, -8'sd63, 8'sd127, -8'sd2,
                                          8'sd2, -8'sd128, 8'sd127, -8'sd125};
    logic signed [7:0] hand_relu1 [8] = '{8'sd127, 8'sd0, 8'sd127, 8'sd0,
                                          8'sd2, 8'sd0, 8'sd127, 8'sd0};

    logic [PE*OW-1:0] first_word;
    logic [PE*OW-1:0] last_word;
    logic [PE*OW-1:0] last_word_b2b;

    always #5 clk = ~clk;

    conv_result_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .shift_i     (shift_i),
        .relu_en_i   (relu_en_i),
        .acc_valid_i (acc_valid_i),
        .acc_data_i  (acc_data_i),
        .mem_addr0   (mem_addr0),
        .mem_ce0     (mem_ce0),
        .mem_we0     (mem_we0),
        .mem_d0      (mem_d0),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o)
    );

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference quantizer: floor division by 2^sh, then clamp to int8.
    function automatic logic [7:0] q_model(input logic signed [31:0] a, input int sh, input bit relu);
        longint v;
        longint d;
        longint q;
        v = a;
        d = longint'(1) << sh;
        if (relu && v < 0) return 8'd0;
        q = v / d;
        if (v < 0 && (v % d) != 0) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    function automatic logic [PE*OW-1:0] expected_word(input logic [PE*AC-1:0] row, input int sh, input bit relu);
        logic [PE*OW-1:0] r;
        r = '0;
        for (int i = 0; i < PE; i++) r[i*OW +: OW] = q_model(row[i*AC +: AC], sh, relu);
        return r;
    endfunction

    // mode 0: lane i = (row + i) mod 100; mode 1: corner values in rotation.
    function automatic logic [PE*AC-1:0] row_data(input int row, input int mode);
        logic [PE*AC-1:0] r;
        r = '0;
        for (int i = 0; i < PE; i++) begin
            if (mode == 0) r[i*AC +: AC] = 32'((row + i) % 100);
            else           r[i*AC +: AC] = qvals[(row + i) % 8];
        end
        return r;
    endfunction

    // Apply inputs for one cycle, then settle 1 time unit past the edge.
    task automatic step(input logic valid, input logic [PE*AC-1:0] data);
        acc_valid_i = valid;
        acc_data_i  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic run_tile(input int sh, input bit relu, input int mode, input int gap,
                            input bit extras, output logic [PE*OW-1:0] first_out,
                            output logic [PE*OW-1:0] last_out);
        logic [PE*OW-1:0] exp_word;
        first_out = '0;
        shift_i   = 5'(sh);
        relu_en_i = relu;
        start_i   = 1'b1;
        step(1'b0, '0);
        start_i   = 1'b0;
        shift_i   = 5'd0;
        relu_en_i = 1'b0;
        check("start_busy", busy_o, 1);
        check("start_ovf_clear", overflow_o, 0);
        check("start_no_write", mem_ce0, 0);
        for (int row = 0; row < MEM_DEPTH; row++) begin
            for (int g = 0; g < gap; g++) begin
                step(1'b0, row_data(row + 37, mode));
                check("gap_no_write", mem_ce0, 0);
                if (row > 0) check("gap_addr_hold", mem_addr0, row - 1);
            end
            if (extras && row == 100) start_i = 1'b1;
            exp_word = expected_word(row_data(row, mode), sh, relu);
            step(1'b1, row_data(row, mode));
            start_i = 1'b0;
            check("wr_ce", mem_ce0, 1);
            check("wr_we", mem_we0, 1);
            check("wr_addr", mem_addr0, row);
            check("wr_data", mem_d0, exp_word);
            if (row == 0) first_out = mem_d0;
        end
        last_out = mem_d0;
        check("flush_busy", busy_o, 1);
        check("flush_done_low", done_o, 0);
        step(extras, row_data(5, mode));
        check("done_pulse", done_o, 1);
        check("done_busy", busy_o, 1);
        check("done_no_write", mem_ce0, 0);
        check("done_addr_hold", mem_addr0, MEM_DEPTH - 1);
        check("done_ovf", overflow_o, extras);
        if (extras) start_i = 1'b1;
        step(1'b0, '0);
        start_i = 1'b0;
        check("idle_done_low", done_o, 0);
        check("idle_busy_low", busy_o, 0);
        step(1'b0, '0);
        check("start_in_done_ignored", busy_o, 0);
        check("idle_no_write", mem_ce0, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        shift_i     = 5'd0;
        relu_en_i   = 1'b0;
        acc_valid_i = 1'b0;
        acc_data_i  = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, '0);
            check("idle_ce", mem_ce0, 0);
        end
        check("rst_addr", mem_addr0, 0);
        check("rst_data", mem_d0, 0);
        check("rst_we", mem_we0, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ovf", overflow_o, 0);

        // Full back-to-back tile, shift 0, no ReLU
        run_tile(0, 1'b0, 0, 0, 1'b0, first_word, last_word_b2b);

        // Valid while idle: dropped and flagged
        step(1'b1, row_data(3, 0));
        check("idle_valid_no_write", mem_ce0, 0);
        check("idle_valid_ovf", overflow_o, 1);
        check("idle_valid_busy", busy_o, 0);

        // Quantization corners, shift 4, ReLU off
        run_tile(4, 1'b0, 1, 0, 1'b0, first_word, last_word);
        for (int i = 0; i < 8; i++) check("quant_relu0_lane", first_word[i*OW +: OW], $unsigned(hand_relu0[i]));

        // Same with ReLU on, plus start in RUN/DONE and valid after last row
        run_tile(4, 1'b1, 1, 0, 1'b1, first_word, last_word);
        for (int i = 0; i < 8; i++) check("quant_relu1_lane", first_word[i*OW +: OW], $unsigned(hand_relu1[i]));

        // Gapped input: 1 valid, 2 idle
        run_tile(0, 1'b0, 0, 2, 1'b0, first_word, last_word);
        check("gapped_final_data", last_word, last_word_b2b);

        // Reset after 300 words
        shift_i = 5'd0;
        start_i = 1'b1;
        step(1'b0, '0);
        start_i = 1'b0;
        for (int row = 0; row < 300; row++) begin
            step(1'b1, row_data(row, 0));
            check("pre_rst_addr", mem_addr0, row);
        end
        acc_valid_i = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_ce", mem_ce0, 0);
        check("midrst_addr", mem_addr0, 0);
        check("midrst_data", mem_d0, 0);
        check("midrst_busy", busy_o, 0);
        step(1'b1, row_data(300, 0));
        check("midrst_hold_ce", mem_ce0, 0);
        check("midrst_hold_ovf", overflow_o, 0);
        step(1'b0, '0);
        rst_n = 1'b1;
        step(1'b0, '0);
        check("post_rst_busy", busy_o, 0);
        run_tile(0, 1'b0, 0, 0, 1'b0, first_word, last_word);
        check("restart_final_data", last_word, last_word_b2b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
